uart_tx: RTL and testbench



---
 rtl/uart_pkg.sv | 16 +
 rtl/flex_counter.sv | 36 +++
 rtl/uart_tx.sv | 128 ++++++++++++
 tb/tb_uart_tx.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared link definitions for the 8N1 serial transmitter and receiver.
package uart_pkg;

  // Transmitter frame states.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } tx_state_t;

  // Line levels of the framing bits.
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/flex_counter.sv
// Wrapping up-counter: counts 1..rollover_val and flags when the final value is held.
module flex_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             count_enable,
  input  logic [WIDTH-1:0] rollover_val,
  output logic             rollover_flag
);

  logic [WIDTH-1:0] count_q, count_d;

  // Next count: clear wins; otherwise step, wrapping from rollover_val back to 1.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_enable) begin
      count_d = (count_q == rollover_val) ? WIDTH'(1) : count_q + WIDTH'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign rollover_flag = (count_q == rollover_val);

endmodule

// File: rtl/uart_tx.sv
// 8N1 serial transmitter: start bit, DATA_BITS data bits LSB first, stop bit,
// each held for BIT_PERIOD clocks. Line output is registered and idles high.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned BIT_PERIOD = 8,
  parameter int unsigned DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_start,
  output logic                 serial_out,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int unsigned TimerW = $clog2(BIT_PERIOD + 1);
  localparam int unsigned BitW   = $clog2(DATA_BITS + 1);
  localparam logic [TimerW-1:0] TimerRoll = TimerW'(BIT_PERIOD);
  localparam logic [BitW-1:0]   BitRoll   = BitW'(DATA_BITS);

  tx_state_t            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 serial_q, serial_d;
  logic                 done_q, done_d;

  logic timer_clear, timer_en, timer_roll;
  logic bit_clear, bit_en, bit_roll;

  // Bit timer runs in every non-idle state. Its wrap from BIT_PERIOD to 1 lines up with
  // each state change, so every bit starts at count 1.
  assign timer_clear = (state_d == IDLE);
  assign timer_en    = (state_d != IDLE);

  // Bit counter steps on the edge entering DATA and at the end of each data bit, so it
  // reads k+1 while data bit k is on the line; it is held at 0 outside DATA.
  assign bit_clear = (state_d != DATA);
  assign bit_en    = timer_roll;

  flex_counter #(
    .WIDTH(TimerW)
  ) u_bit_timer (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (timer_clear),
    .count_enable (timer_en),
    .rollover_val (TimerRoll),
    .rollover_flag(timer_roll)
  );

  flex_counter #(
    .WIDTH(BitW)
  ) u_bit_counter (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (bit_clear),
    .count_enable (bit_en),
    .rollover_val (BitRoll),
    .rollover_flag(bit_roll)
  );

  // Next state, shift register and line level. The line is derived from the next state
  // so the registered output changes on the same edge as the state.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    done_d   = 1'b0;
    serial_d = STOP_BIT;

    unique case (state_q)
      IDLE: begin
        if (tx_start) begin
          state_d = START;
          shift_d = tx_data;
        end
      end
      START: begin
        if (timer_roll) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (timer_roll) begin
          shift_d = shift_q >> 1;
          if (bit_roll) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (timer_roll) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    unique case (state_d)
      IDLE:    serial_d = STOP_BIT;
      START:   serial_d = START_BIT;
      DATA:    serial_d = shift_d[0];
      STOP:    serial_d = STOP_BIT;
      default: serial_d = STOP_BIT;
    endcase
  end

  // State, shift and output registers; reset forces the line high at once.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      serial_q <= STOP_BIT;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      serial_q <= serial_d;
      done_q   <= done_d;
    end
  end

  assign serial_out = serial_q;
  assign tx_busy    = (state_q != IDLE);
  assign tx_done    = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a default instance (8 clocks/bit, 8 data bits) and a small one
// (2 clocks/bit, 5 data bits). Stimulus pushes expected frames; a receiver-style monitor
// per instance decodes the line and compares against them.
module tb_uart_tx;

  typedef struct {
    logic [7:0] data;
    int         a;     // edge on which the start strobe is sampled
  } frame_t;

  logic       clk;
  logic       n_rst;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       serial_out, tx_busy, tx_done;
  logic [4:0] tx_data2;
  logic       tx_start2;
  logic       serial_out2, tx_busy2, tx_done2;

  int     cyc = 0;
  int     total = 0;
  int     bad = 0;
  int     next_ok [2];
  frame_t q0[$];
  frame_t q1[$];

  uart_tx dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .serial_out(serial_out),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done)
  );

  uart_tx #(
    .BIT_PERIOD(2),
    .DATA_BITS (5)
  ) dut2 (
    .clk       (clk),
    .n_rst     (n_rst),
    .tx_data   (tx_data2),
    .tx_start  (tx_start2),
    .serial_out(serial_out2),
    .tx_busy   (tx_busy2),
    .tx_done   (tx_done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int want);
    total = total + 1;
    if (got != want) begin
      bad = bad + 1;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic int frame_len(input int w);
    // start + data + stop, each one bit period long
    return (w == 0) ? (8 + 2) * 8 : (5 + 2) * 2;
  endfunction

  function automatic logic line_of(input int w);
    return (w == 0) ? serial_out : serial_out2;
  endfunction

  function automatic logic busy_of(input int w);
    return (w == 0) ? tx_busy : tx_busy2;
  endfunction

  function automatic logic done_of(input int w);
    return (w == 0) ? tx_done : tx_done2;
  endfunction

  function automatic int qsize(input int w);
    return (w == 0) ? q0.size() : q1.size();
  endfunction

  function automatic frame_t qpop(input int w);
    if (w == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  // Called at posedge+1; the strobe is sampled on the next edge. The model accepts it
  // only if the previous frame's done cycle has been reached.
  task automatic strobe(input int w, input logic [7:0] d, output int a);
    frame_t f;
    if (w == 0) begin
      tx_data  = d;
      tx_start = 1'b1;
    end else begin
      tx_data2  = d[4:0];
      tx_start2 = 1'b1;
    end
    a = cyc + 1;
    if (a >= next_ok[w]) begin
      f.data = (w == 0) ? d : (d & 8'h1F);
      f.a    = a;
      if (w == 0) q0.push_back(f);
      else q1.push_back(f);
      next_ok[w] = a + frame_len(w) + 1;
    end
    @(posedge clk);
    #1;
    tx_start  = 1'b0;
    tx_start2 = 1'b0;
  endtask

  task automatic wait_until(input int e);
    while (cyc < e) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Idle cycles with random churn on the data inputs.
  task automatic gap(input int n);
    repeat (n) begin
      if ($urandom_range(0, 2) == 0) begin
        tx_data  = 8'($urandom);
        tx_data2 = 5'($urandom);
      end
      @(posedge clk);
      #1;
    end
  endtask

  // Receiver model: on a falling line, sample mid-bit, check status every cycle of the
  // frame and the done cycle, then compare with the next expected frame.
  task automatic monitor(input int w);
    int         bp, db, fl, s;
    logic [9:0] bits, want;
    logic       have, aborted;
    frame_t     e;
    string      tag;
    bp  = (w == 0) ? 8 : 2;
    db  = (w == 0) ? 8 : 5;
    fl  = frame_len(w);
    tag = (w == 0) ? "dut0" : "dut1";
    forever begin
      @(negedge clk);
      if (n_rst !== 1'b1) continue;
      if (line_of(w) !== 1'b0) begin
        check({tag, "_idle_line"}, int'(line_of(w)), 1);
        check({tag, "_idle_busy"}, int'(busy_of(w)), 0);
        check({tag, "_idle_done"}, int'(done_of(w)), 0);
      end else begin
        s    = cyc;
        have = (qsize(w) > 0);
        check({tag, "_frame_expected"}, int'(have), 1);
        e.data = 8'h00;
        e.a    = -1;
        if (have) e = qpop(w);
        bits    = '0;
        aborted = 1'b0;
        for (int j = 0; j < fl; j++) begin
          if (j > 0) @(negedge clk);
          if (n_rst !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
          check({tag, "_frame_busy"}, int'(busy_of(w)), 1);
          check({tag, "_frame_done"}, int'(done_of(w)), 0);
          if (j % bp == bp / 2 - 1) bits[j / bp] = line_of(w);
        end
        if (!aborted) begin
          @(negedge clk);
          if (n_rst === 1'b1) begin
            check({tag, "_end_done"}, int'(done_of(w)), 1);
            check({tag, "_end_busy"}, int'(busy_of(w)), 0);
            check({tag, "_end_line"}, int'(line_of(w)), 1);
            if (have) begin
              check({tag, "_start_edge"}, s, e.a);
              want = '0;
              for (int k = 0; k < db; k++) want[k + 1] = e.data[k];
              want[db + 1] = 1'b1;
              check({tag, "_frame_bits"}, int'(bits), int'(want));
            end
          end
        end
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int a, a2, dummy;
    n_rst      = 1'b0;
    tx_data    = 8'h00;
    tx_start   = 1'b0;
    tx_data2   = 5'h00;
    tx_start2  = 1'b0;
    next_ok[0] = 0;
    next_ok[1] = 0;

    // Reset state, then 20 quiet cycles watched by the monitors.
    repeat (3) @(posedge clk);
    #3;
    check("rst_line", int'(serial_out), 1);
    check("rst_busy", int'(tx_busy), 0);
    check("rst_done", int'(tx_done), 0);
    check("rst_line2", int'(serial_out2), 1);
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    gap(20);

    // A5 frame; a second strobe at cycle 30 and data churn must not disturb it.
    strobe(0, 8'hA5, a);
    wait_until(a + 29);
    strobe(0, 8'h3C, dummy);
    tx_data = 8'h5A;
    gap(10);
    tx_data = 8'hFF;
    wait_until(next_ok[0]);
    gap(5);

    // Back-to-back: second strobe lands in the tx_done cycle of the first.
    strobe(0, 8'h00, a);
    wait_until(a + frame_len(0));
    strobe(0, 8'hFF, a2);
    wait_until(next_ok[0]);
    gap(5);

    // Reset during data bit 3 of an all-zero frame: line must rise without a clock.
    strobe(0, 8'h00, a);
    wait_until(a + 39);
    #1;
    n_rst = 1'b0;
    #1;
    check("midrst_line", int'(serial_out), 1);
    check("midrst_busy", int'(tx_busy), 0);
    check("midrst_done", int'(tx_done), 0);
    q0.delete();
    q1.delete();
    next_ok[0] = 0;
    next_ok[1] = 0;
    repeat (2) @(posedge clk);
    #3;
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    strobe(0, 8'h81, a);
    wait_until(next_ok[0]);
    gap(5);

    // Small configuration: 5'h13 over a 14-clock frame.
    strobe(1, 8'h13, a);
    wait_until(next_ok[1]);
    gap(3);

    // Random traffic; some strobes land while busy and must be dropped.
    for (int i = 0; i < 40; i++) begin
      gap($urandom_range(0, 90));
      strobe(0, 8'($urandom), dummy);
    end
    wait_until(next_ok[0]);
    for (int i = 0; i < 40; i++) begin
      gap($urandom_range(0, 20));
      strobe(1, 8'($urandom), dummy);
    end
    wait_until(next_ok[1]);
    gap(10);

    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
